// File: rtl/video_fetch_pkg.sv
// Shared types and widths for the video line fetcher.
package video_fetch_pkg;

    localparam int VRAM_ADDR_W = 16;
    localparam int VRAM_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/video_fetch_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
// DEPTH must be a power of two (>= 2). A push while full is accepted
// only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = count_q;

    // Head byte is visible without a read request; drives zero when empty.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/video_fetch.sv
// Video line fetcher: issues sequential VRAM reads for one line and
// streams the returned bytes through a pixel FIFO in address order.
//
//   state    | meaning
//   ---------+------------------------------------------------------
//   ST_IDLE  | waiting for line_start; busy low
//   ST_FETCH | claiming VRAM read slots until all line bytes issued
//   ST_DRAIN | all reads issued; waiting for counted returns to land
//
// Each accepted VRAM slot pushes a 1-bit tag (1 = counted line fetch,
// 0 = idle slot) so returns can be matched in order. A slot is only
// counted when the FIFO is guaranteed room for its byte, so the pixel
// FIFO can never overflow. MAX_INFLIGHT and FIFO_DEPTH must be powers
// of two (>= 2).
module video_fetch
    import video_fetch_pkg::*;
#(
    parameter int LINE_BYTES   = 80,
    parameter int FIFO_DEPTH   = 16,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        line_start,
    input  logic [15:0] line_addr,
    output logic        busy,
    output logic        line_err,
    output logic [15:0] vram_addr,
    output logic        vram_write_enable,
    output logic [7:0]  vram_data_in,
    input  logic        vram_input_valid,
    input  logic [7:0]  vram_data_out,
    input  logic        vram_data_out_valid,
    output logic [7:0]  pix_data,
    output logic        pix_valid,
    input  logic        pix_ready
);

    localparam int TAW   = $clog2(MAX_INFLIGHT);
    localparam int FAW   = $clog2(FIFO_DEPTH);
    localparam int SUM_W = ((FAW > TAW) ? FAW : TAW) + 2;

    fetch_state_t state_q;
    fetch_state_t state_d;

    logic [VRAM_ADDR_W-1:0]  next_addr_q;
    logic [7:0]              remaining_q;
    logic                    line_err_q;

    logic [MAX_INFLIGHT-1:0] tag_mem;
    logic [TAW-1:0]          tag_wr;
    logic [TAW-1:0]          tag_rd;
    logic [TAW:0]            tag_count;
    logic [TAW:0]            inflight_q;

    logic                    tag_full;
    logic                    tag_empty;
    logic                    tag_push;
    logic                    tag_pop;
    logic                    tag_head;
    logic                    counted;
    logic                    accept;
    logic                    fifo_push;
    logic                    fifo_empty;
    logic [FAW:0]            fifo_count;
    logic [SUM_W-1:0]        committed;

    assign tag_full  = (tag_count == (TAW+1)'(MAX_INFLIGHT));
    assign tag_empty = (tag_count == '0);
    assign tag_push  = vram_input_valid && !tag_full;
    assign tag_pop   = vram_data_out_valid && !tag_empty;
    assign tag_head  = tag_mem[tag_rd];
    assign fifo_push = tag_pop && tag_head;

    // Bytes already buffered plus bytes promised by outstanding counted reads.
    assign committed = SUM_W'(fifo_count) + SUM_W'(inflight_q);

    assign counted = vram_input_valid && (state_q == ST_FETCH) &&
                     (remaining_q != 8'd0) && !tag_full &&
                     (committed < SUM_W'(FIFO_DEPTH));

    assign accept = (state_q == ST_IDLE) && line_start;

    assign busy              = (state_q != ST_IDLE);
    assign line_err          = line_err_q;
    assign vram_addr         = next_addr_q;
    assign vram_write_enable = 1'b0;
    assign vram_data_in      = '0;
    assign pix_valid         = !fifo_empty;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state: DRAIN exits on the same edge the last counted byte lands.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (line_start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if ((remaining_q == 8'd0) || (counted && (remaining_q == 8'd1)))
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if ((inflight_q == '0) ||
                    ((inflight_q == (TAW+1)'(1)) && fifo_push))
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Line address/length tracking and the busy-collision pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            next_addr_q <= '0;
            remaining_q <= '0;
            line_err_q  <= 1'b0;
        end else begin
            line_err_q <= line_start && (state_q != ST_IDLE);
            if (accept) begin
                next_addr_q <= line_addr;
                remaining_q <= 8'(LINE_BYTES);
            end else if (counted) begin
                next_addr_q <= next_addr_q + 16'd1;
                remaining_q <= remaining_q - 8'd1;
            end
        end
    end

    // Tag queue pointers and count of counted reads still outstanding.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_wr     <= '0;
            tag_rd     <= '0;
            tag_count  <= '0;
            inflight_q <= '0;
        end else begin
            if (tag_push) tag_wr <= tag_wr + TAW'(1);
            if (tag_pop)  tag_rd <= tag_rd + TAW'(1);
            case ({tag_push, tag_pop})
                2'b10:   tag_count <= tag_count + (TAW+1)'(1);
                2'b01:   tag_count <= tag_count - (TAW+1)'(1);
                default: tag_count <= tag_count;
            endcase
            case ({counted, fifo_push})
                2'b10:   inflight_q <= inflight_q + (TAW+1)'(1);
                2'b01:   inflight_q <= inflight_q - (TAW+1)'(1);
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    // Tag storage; a slot's tag records whether its return belongs to the line.
    always_ff @(posedge clk) begin
        if (tag_push) tag_mem[tag_wr] <= counted;
    end

    sync_fifo #(
        .WIDTH (VRAM_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_pix_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (vram_data_out),
        .pop       (pix_ready),
        .pop_data  (pix_data),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_video_fetch.sv
// Bench for video_fetch: VRAM model with a slot every 4th clock and
// 3-cycle read latency, memory[a] = a[7:0] ^ 8'h5A.
module tb_video_fetch;

    localparam int LB = 80;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        line_start = 1'b0;
    logic [15:0] line_addr = 16'h0000;
    logic        busy;
    logic        line_err;
    logic [15:0] vram_addr;
    logic        vram_write_enable;
    logic [7:0]  vram_data_in;
    logic        vram_input_valid = 1'b0;
    logic [7:0]  vram_data_out = 8'h00;
    logic        vram_data_out_valid = 1'b0;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        pix_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    video_fetch dut (
        .clk                 (clk),
        .reset               (reset),
        .line_start          (line_start),
        .line_addr           (line_addr),
        .busy                (busy),
        .line_err            (line_err),
        .vram_addr           (vram_addr),
        .vram_write_enable   (vram_write_enable),
        .vram_data_in        (vram_data_in),
        .vram_input_valid    (vram_input_valid),
        .vram_data_out       (vram_data_out),
        .vram_data_out_valid (vram_data_out_valid),
        .pix_data            (pix_data),
        .pix_valid           (pix_valid),
        .pix_ready           (pix_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // VRAM model, advanced on the falling edge so inputs are stable at posedge.
    int          cyc = 0;
    logic        dv [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic [15:0] da [4] = '{16'h0, 16'h0, 16'h0, 16'h0};
    logic        spur_req = 1'b0;

    always @(negedge clk) begin
        cyc++;
        for (int k = 3; k > 0; k--) begin
            dv[k] = dv[k-1];
            da[k] = da[k-1];
        end
        dv[0] = ((cyc % 4) == 0);
        da[0] = vram_addr;
        vram_input_valid = dv[0];
        if (spur_req) begin
            vram_data_out_valid = 1'b1;
            vram_data_out       = 8'hEE;
            spur_req            = 1'b0;
        end else begin
            vram_data_out_valid = dv[3];
            vram_data_out       = da[3][7:0] ^ 8'h5A;
        end
    end

    // Pixel consumer / event monitor.
    logic [7:0]  rx_q [$];
    int          err_cycles = 0;
    logic [15:0] prev_addr = 16'h0000;
    bit          saw_wrap = 0;
    logic        prev_busy = 1'b0;
    bit          bf_seen = 0;
    logic        bf_valid = 1'b0;
    logic [7:0]  bf_data = 8'h00;

    always @(negedge clk) begin
        #1;
        if (!reset) begin
            if (prev_busy && !busy && !bf_seen) begin
                bf_seen  = 1;
                bf_valid = pix_valid;
                bf_data  = pix_data;
            end
            prev_busy = busy;
            if (pix_valid && pix_ready) rx_q.push_back(pix_data);
            if (line_err) err_cycles++;
            if (prev_addr == 16'hFFFF && vram_addr == 16'h0000) saw_wrap = 1;
            prev_addr = vram_addr;
        end else begin
            prev_busy = 1'b0;
        end
    end

    typedef struct {
        logic [15:0] addr;
        bit          stall;
        bit          dbl;
        bit          wrap;
        logic [7:0]  first_exp;
        logic [7:0]  last_exp;
        logic [15:0] stall_addr;
    } vec_t;

    vec_t vecs [4];

    task automatic run_line(input vec_t v, input string tag);
        int t;
        int bad;
        logic [15:0] a;
        rx_q.delete();
        err_cycles = 0;
        saw_wrap   = 0;
        bf_seen    = 0;
        @(negedge clk);
        pix_ready  = !v.stall;
        line_addr  = v.addr;
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        #1 check({tag, " busy_after_start"}, busy, 1);
        if (v.dbl) begin
            repeat (4) @(negedge clk);
            line_start = 1'b1;
            line_addr  = 16'h4000;
            @(negedge clk);
            line_start = 1'b0;
            #1 check({tag, " line_err_pulse"}, line_err, 1);
            @(negedge clk);
            #1 check({tag, " line_err_cleared"}, line_err, 0);
        end
        if (v.stall) begin
            repeat (300) @(negedge clk);
            #1;
            check({tag, " stall_vram_addr"}, vram_addr, v.stall_addr);
            check({tag, " stall_pix_valid"}, pix_valid, 1);
            check({tag, " stall_pix_head"}, pix_data, v.first_exp);
            check({tag, " stall_busy"}, busy, 1);
            check({tag, " stall_nothing_taken"}, rx_q.size(), 0);
            @(negedge clk);
            pix_ready = 1'b1;
        end
        t = 0;
        while ((rx_q.size() < LB || busy) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check({tag, " line_done_in_time"}, (t < 3000), 1);
        repeat (20) @(negedge clk);
        #1;
        check({tag, " byte_count"}, rx_q.size(), LB);
        check({tag, " busy_low_at_end"}, busy, 0);
        check({tag, " fifo_empty_at_end"}, pix_valid, 0);
        check({tag, " line_err_cycles"}, err_cycles, v.dbl ? 1 : 0);
        check({tag, " busy_fall_seen"}, bf_seen, 1);
        check({tag, " last_byte_buffered_at_busy_fall"}, {bf_valid, bf_data}, {1'b1, v.last_exp});
        if (rx_q.size() >= LB) begin
            check({tag, " first_byte"}, rx_q[0], v.first_exp);
            check({tag, " last_byte"}, rx_q[LB-1], v.last_exp);
        end
        bad = 0;
        for (int i = 0; i < rx_q.size(); i++) begin
            a = v.addr + 16'(i);
            if (rx_q[i] !== (a[7:0] ^ 8'h5A)) bad++;
        end
        check({tag, " bytes_in_address_order"}, bad, 0);
        if (v.wrap) check({tag, " vram_addr_wrapped"}, saw_wrap, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        vec_t v2000;
        vecs[0] = '{16'h1000, 1'b0, 1'b0, 1'b0, 8'h5A, 8'h15, 16'h0000};
        vecs[1] = '{16'hFFF8, 1'b0, 1'b0, 1'b1, 8'hA2, 8'h1D, 16'h0000};
        vecs[2] = '{16'h0520, 1'b1, 1'b0, 1'b0, 8'h7A, 8'h35, 16'h0530};
        vecs[3] = '{16'h1000, 1'b0, 1'b1, 1'b0, 8'h5A, 8'h15, 16'h0000};
        v2000   = '{16'h2000, 1'b0, 1'b0, 1'b0, 8'h5A, 8'h15, 16'h0000};

        repeat (3) @(negedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset line_err", line_err, 0);
        check("reset vram_addr", vram_addr, 16'h0000);
        check("reset pix_valid", pix_valid, 0);
        check("reset pix_data", pix_data, 8'h00);
        check("vram_write_enable", vram_write_enable, 0);
        check("vram_data_in", vram_data_in, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Return with no tag outstanding must be discarded.
        @(posedge clk);
        #1 spur_req = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check("untagged return dropped", pix_valid, 0);
        check("untagged return idle", busy, 0);

        for (int i = 0; i < 4; i++) begin
            run_line(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of a line.
        rx_q.delete();
        @(negedge clk);
        pix_ready  = 1'b1;
        line_addr  = 16'h3000;
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        t = 0;
        while (rx_q.size() < 10 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("midline ten bytes seen", (t < 1000), 1);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("midreset busy", busy, 0);
        check("midreset line_err", line_err, 0);
        check("midreset vram_addr", vram_addr, 16'h0000);
        check("midreset pix_valid", pix_valid, 0);
        check("midreset pix_data", pix_data, 8'h00);
        reset = 1'b0;
        rx_q.delete();
        repeat (12) @(negedge clk);
        #1;
        check("stale returns dropped", rx_q.size(), 0);
        check("stale pix_valid", pix_valid, 0);
        run_line(v2000, "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
